// File: rtl/sync_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_tx_pkg
// Purpose  : Shared definitions for the sync_tx K/J line transmitter: FSM
//            state encodings, line-symbol constants and SYNC pattern helper.
//            The receiver-side bench reuses these.
// Revision : 1.0 - initial release
// ============================================================================
package sync_tx_pkg;

    // FSM state encodings
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SYNC = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_EOP  = 2'd3;

    // Line symbols packed as {k, j}; (1,1) is never used
    localparam logic [1:0] c_SYM_K   = 2'b10;
    localparam logic [1:0] c_SYM_J   = 2'b01;
    localparam logic [1:0] c_SYM_SE0 = 2'b00;

    // NRZI line level: 1 = K, 0 = J
    localparam logic c_LVL_K = 1'b1;
    localparam logic c_LVL_J = 1'b0;

    // SYNC symbol idx of a len-symbol pattern: K on even slots and on the
    // final slot, J otherwise. Error injection turns the final K into J.
    function automatic logic sync_is_k(input int idx, input int len, input logic err);
        if (idx == len - 1) begin
            return !err;
        end
        return ((idx % 2) == 0);
    endfunction

    // Map an NRZI level onto the {k, j} line pair
    function automatic logic [1:0] level_to_sym(input logic lvl);
        return lvl ? c_SYM_K : c_SYM_J;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_tx_nrzi.sv
`default_nettype none
// ============================================================================
// Module   : sync_tx_nrzi
// Purpose  : NRZI encoder with bit stuffing. Holds the reference line level
//            and the run-of-ones counter. 'level' is the level to drive for
//            the bit presented this cycle; 'stuff_now' says a stuffed 0 is
//            being sent instead, so the caller must not advance its bit index.
// Revision : 1.0 - initial release
// ============================================================================
module sync_tx_nrzi
    import sync_tx_pkg::*;
#(
    parameter int STUFF_RUN = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic init_level,
    input  logic bit_valid,
    input  logic bit_in,
    output logic level,
    output logic stuff_now
);

    localparam int c_ONES_W = $clog2(STUFF_RUN + 1);

    logic                r_level;
    logic [c_ONES_W-1:0] r_ones;
    logic                w_tx_bit;

    // A full run of ones forces a 0 regardless of the payload bit
    assign stuff_now = (r_ones == c_ONES_W'(STUFF_RUN));
    assign w_tx_bit  = stuff_now ? 1'b0 : bit_in;
    // 0 toggles the line, 1 holds it
    assign level     = w_tx_bit ? r_level : ~r_level;

    // Track reference level and consecutive-ones run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= c_LVL_J;
            r_ones  <= '0;
        end else if (init) begin
            r_level <= init_level;
            r_ones  <= '0;
        end else if (bit_valid) begin
            r_level <= level;
            r_ones  <= w_tx_bit ? (r_ones + 1'b1) : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_tx.sv
`default_nettype none
// ============================================================================
// Module   : sync_tx
// Purpose  : K/J line transmitter. On start sends SYNC, an NRZI bit-stuffed
//            payload (LSB first) and an SE0 end-of-packet, then returns to
//            idle J with a one-cycle done pulse. k/j/tx_en/done are
//            registered; each register holds the symbol currently on the line.
// Revision : 1.0 - initial release
// ============================================================================
module sync_tx
    import sync_tx_pkg::*;
#(
    parameter int SYNC_LEN  = 8,
    parameter int DATA_W    = 8,
    parameter int EOP_LEN   = 2,
    parameter int STUFF_RUN = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_inj,
    output logic              ready,
    output logic              done,
    output logic              k,
    output logic              j,
    output logic              tx_en
);

    localparam int c_CNT_MAX = (SYNC_LEN > EOP_LEN) ? SYNC_LEN : EOP_LEN;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam int c_BIT_W   = $clog2(DATA_W + 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_BIT_W-1:0] r_bits;     // payload bits already sent
    logic [DATA_W-1:0]  r_data;     // shifts right; bit 0 is the next to send
    logic               r_err;
    logic               r_k;
    logic               r_j;
    logic               r_tx_en;
    logic               r_done;

    logic               w_sync_last;
    logic               w_eop_last;
    logic               w_bits_done;
    logic               w_init;
    logic               w_init_level;
    logic               w_bit_valid;
    logic               w_level;
    logic               w_stuff_now;

    assign w_sync_last = (r_cnt == c_CNT_W'(SYNC_LEN - 1));
    assign w_eop_last  = (r_cnt == c_CNT_W'(EOP_LEN - 1));
    assign w_bits_done = (r_bits == c_BIT_W'(DATA_W));

    // Encoder control: every SYNC symbol reloads the reference level, so the
    // last SYNC symbol becomes the NRZI starting point for the payload.
    always_comb begin
        w_init       = 1'b0;
        w_init_level = c_LVL_K;
        w_bit_valid  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_init       = 1'b1;
                    w_init_level = sync_is_k(0, SYNC_LEN, err_inj);
                end
            end
            c_SYNC: begin
                if (!w_sync_last) begin
                    w_init       = 1'b1;
                    w_init_level = sync_is_k(32'(r_cnt) + 32'd1, SYNC_LEN, r_err);
                end else begin
                    w_bit_valid  = 1'b1;
                end
            end
            c_DATA: begin
                // A pending stuffed bit is sent even after the last data bit
                w_bit_valid = !w_bits_done || w_stuff_now;
            end
            default: begin
                w_bit_valid = 1'b0;
            end
        endcase
    end

    sync_tx_nrzi #(
        .STUFF_RUN (STUFF_RUN)
    ) u_nrzi (
        .clk        (CLK),
        .rst        (RST),
        .init       (w_init),
        .init_level (w_init_level),
        .bit_valid  (w_bit_valid),
        .bit_in     (r_data[0]),
        .level      (w_level),
        .stuff_now  (w_stuff_now)
    );

    // Packet FSM: each transition loads the symbol for the following cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_k     <= 1'b0;
            r_j     <= 1'b1;
            r_tx_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state      <= c_SYNC;
                        r_cnt        <= '0;
                        r_bits       <= '0;
                        r_data       <= data_in;
                        r_err        <= err_inj;
                        {r_k, r_j}   <= level_to_sym(w_init_level);
                        r_tx_en      <= 1'b1;
                    end
                end
                c_SYNC: begin
                    if (!w_sync_last) begin
                        r_cnt        <= r_cnt + 1'b1;
                        {r_k, r_j}   <= level_to_sym(w_init_level);
                    end else begin
                        r_state      <= c_DATA;
                        {r_k, r_j}   <= level_to_sym(w_level);
                        r_data       <= r_data >> 1;
                        r_bits       <= c_BIT_W'(1);
                    end
                end
                c_DATA: begin
                    if (w_bit_valid) begin
                        {r_k, r_j} <= level_to_sym(w_level);
                        if (!w_stuff_now) begin
                            r_data <= r_data >> 1;
                            r_bits <= r_bits + 1'b1;
                        end
                    end else begin
                        r_state    <= c_EOP;
                        r_cnt      <= '0;
                        {r_k, r_j} <= c_SYM_SE0;
                    end
                end
                c_EOP: begin
                    if (!w_eop_last) begin
                        r_cnt      <= r_cnt + 1'b1;
                    end else begin
                        r_state    <= c_IDLE;
                        {r_k, r_j} <= c_SYM_J;
                        r_tx_en    <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == c_IDLE);
    assign done  = r_done;
    assign k     = r_k;
    assign j     = r_j;
    assign tx_en = r_tx_en;

endmodule
`default_nettype wire
